// File: rtl/logic_op_sequencer_if.sv
// Operand interface between the logic-op sequencer and its environment:
// control handshake, register-file ports and logic-unit ports.
// zero is present only when LOGIC_SEQ_ZERO_FLAG_EN is defined.
interface logic_op_sequencer_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              start;
    logic [1:0]        op;
    logic [ADDR_W-1:0] src1_addr;
    logic [ADDR_W-1:0] src2_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_raddr;
    logic [DATA_W-1:0] rf_rdata;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] lu_inp1;
    logic [DATA_W-1:0] lu_inp2;
    logic [1:0]        lu_op;
    logic [DATA_W-1:0] lu_out;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic              zero;
`endif

    // Sequencer side
    modport master (
        input  start, op, src1_addr, src2_addr, dst_addr, rf_rdata, lu_out,
        output busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata,
               lu_inp1, lu_inp2, lu_op
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        , output zero
`endif
    );

    // Control unit / register file / logic unit side
    modport slave (
        output start, op, src1_addr, src2_addr, dst_addr, rf_rdata, lu_out,
        input  busy, done, rf_raddr, rf_we, rf_waddr, rf_wdata,
               lu_inp1, lu_inp2, lu_op
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        , input zero
`endif
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// Issue/writeback sequencer: reads two registers, drives a registered logic
// unit, waits LU_LATENCY cycles, writes the result back. Optional result-zero
// flag enabled by defining LOGIC_SEQ_ZERO_FLAG_EN.
module logic_op_sequencer #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned LU_LATENCY = 1   // legal range 1..15
) (
    input  logic                 clk,
    input  logic                 rst,
    logic_op_sequencer_if.master bus
);
    localparam int unsigned CNT_W  = 4;
    localparam logic [1:0]  OP_NOT = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD1,
        S_RD2,
        S_LOAD,
        S_EXEC,
        S_WB
    } state_e;

    state_e            state_q;
    logic [1:0]        op_q;
    logic [ADDR_W-1:0] src2_q;
    logic [ADDR_W-1:0] dst_q;
    logic [DATA_W-1:0] opa_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_raddr_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    // lu_inp2_q doubles as the opb operand register
    logic [DATA_W-1:0] lu_inp1_q;
    logic [DATA_W-1:0] lu_inp2_q;
    logic [1:0]        lu_op_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    logic              zero_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            op_q       <= 2'd0;
            src2_q     <= '0;
            dst_q      <= '0;
            opa_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_raddr_q <= '0;
            rf_waddr_q <= '0;
            lu_inp1_q  <= '0;
            lu_inp2_q  <= '0;
            lu_op_q    <= 2'd0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        op_q       <= bus.op;
                        src2_q     <= bus.src2_addr;
                        dst_q      <= bus.dst_addr;
                        rf_raddr_q <= bus.src1_addr;
                        busy_q     <= 1'b1;
                        state_q    <= S_RD1;
                    end
                end
                S_RD1: begin
                    rf_raddr_q <= src2_q;
                    state_q    <= S_RD2;
                end
                S_RD2: begin
                    opa_q   <= bus.rf_rdata;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    // Operands reach the logic unit here and stay put until WB ends
                    lu_inp1_q <= opa_q;
                    lu_inp2_q <= (op_q == OP_NOT) ? '0 : bus.rf_rdata;
                    lu_op_q   <= op_q;
                    cnt_q     <= CNT_W'(LU_LATENCY - 1);
                    state_q   <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_q == '0) begin
                        rf_we_q    <= 1'b1;
                        done_q     <= 1'b1;
                        rf_waddr_q <= dst_q;
                        state_q    <= S_WB;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_WB: begin
                    rf_we_q <= 1'b0;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
                    zero_q  <= (bus.lu_out == '0);
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rf_we    = rf_we_q;
    assign bus.rf_raddr = rf_raddr_q;
    assign bus.rf_waddr = rf_waddr_q;
    // Logic-unit result passes straight through during the WB cycle only
    assign bus.rf_wdata = rf_we_q ? bus.lu_out : '0;
    assign bus.lu_inp1  = lu_inp1_q;
    assign bus.lu_inp2  = lu_inp2_q;
    assign bus.lu_op    = lu_op_q;
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
    assign bus.zero     = zero_q;
`endif

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: one instance with a 1-cycle logic
// unit, one with a 3-cycle logic unit, each with its own register-file model.
module tb_logic_op_sequencer;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start1, start3;
    logic [1:0]  op;
    logic [3:0]  s1, s2, dst;
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [15:0] pre_data;

    logic [15:0] rf1 [16];
    logic [15:0] rf3 [16];
    logic [15:0] rd1_q, rd3_q, lu1_q;
    logic [15:0] lu3_q [3];
    int          we_cnt1, we_cnt3;
    int          tests, fails;

    logic_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus1 ();
    logic_op_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus3 ();

    assign bus1.start     = start1;
    assign bus1.op        = op;
    assign bus1.src1_addr = s1;
    assign bus1.src2_addr = s2;
    assign bus1.dst_addr  = dst;
    assign bus1.rf_rdata  = rd1_q;
    assign bus1.lu_out    = lu1_q;
    assign bus3.start     = start3;
    assign bus3.op        = op;
    assign bus3.src1_addr = s1;
    assign bus3.src2_addr = s2;
    assign bus3.dst_addr  = dst;
    assign bus3.rf_rdata  = rd3_q;
    assign bus3.lu_out    = lu3_q[2];

    logic_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LU_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus1)
    );
    logic_op_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LU_LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(bus3)
    );

    function automatic logic [15:0] lu_f(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~a;
        endcase
    endfunction

    // Register files (1-cycle read latency) and registered logic units
    always @(posedge clk) begin
        if (bus1.rf_we) begin
            rf1[bus1.rf_waddr] <= bus1.rf_wdata;
            we_cnt1 <= we_cnt1 + 1;
        end else if (pre_we) begin
            rf1[pre_addr] <= pre_data;
        end
        if (bus3.rf_we) begin
            rf3[bus3.rf_waddr] <= bus3.rf_wdata;
            we_cnt3 <= we_cnt3 + 1;
        end else if (pre_we) begin
            rf3[pre_addr] <= pre_data;
        end
        rd1_q    <= rf1[bus1.rf_raddr];
        rd3_q    <= rf3[bus3.rf_raddr];
        lu1_q    <= lu_f(bus1.lu_op, bus1.lu_inp1, bus1.lu_inp2);
        lu3_q[0] <= lu_f(bus3.lu_op, bus3.lu_inp1, bus3.lu_inp2);
        lu3_q[1] <= lu3_q[0];
        lu3_q[2] <= lu3_q[1];
    end

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Returns at the negedge of the first cycle after the accepting edge
    task automatic issue(input bit sel, input logic [1:0] o, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] d);
        @(negedge clk);
        op = o; s1 = a; s2 = b; dst = d;
        if (sel) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0; start3 = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input int first, output int n);
        n = first;
        while (((sel ? bus3.done : bus1.done) !== 1'b1) && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (bus1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b exp 0", bus1.busy); end
        tests++; if (bus1.done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b exp 0", bus1.done); end
        tests++; if (bus1.rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b exp 0", bus1.rf_we); end
        tests++; if (bus1.rf_raddr !== 4'h0) begin fails++; $display("FAIL reset_raddr: got %h exp 0", bus1.rf_raddr); end
        tests++; if (bus1.rf_waddr !== 4'h0) begin fails++; $display("FAIL reset_waddr: got %h exp 0", bus1.rf_waddr); end
        tests++; if (bus1.rf_wdata !== 16'h0) begin fails++; $display("FAIL reset_wdata: got %h exp 0", bus1.rf_wdata); end
        tests++; if (bus1.lu_inp1 !== 16'h0 || bus1.lu_inp2 !== 16'h0 || bus1.lu_op !== 2'd0) begin
            fails++; $display("FAIL reset_lu: got %h %h %h exp 0 0 0", bus1.lu_inp1, bus1.lu_inp2, bus1.lu_op);
        end
        tests++; if (bus3.busy !== 1'b0 || bus3.rf_we !== 1'b0) begin
            fails++; $display("FAIL reset_dut3: got busy %b we %b exp 0 0", bus3.busy, bus3.rf_we);
        end
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        tests++; if (bus1.zero !== 1'b0) begin fails++; $display("FAIL reset_zero: got %b exp 0", bus1.zero); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_and();
        int n;
        issue(1'b0, 2'd0, 4'd1, 4'd2, 4'd3);
        tests++; if (bus1.busy !== 1'b1) begin fails++; $display("FAIL and_busy_rd1: got %b exp 1", bus1.busy); end
        wait_done(1'b0, 1, n);
        tests++; if (n != 5) begin fails++; $display("FAIL and_latency: got %0d exp 5", n); end
        tests++; if (bus1.rf_we !== 1'b1 || bus1.rf_waddr !== 4'd3) begin
            fails++; $display("FAIL and_write: got we %b addr %h exp 1 3", bus1.rf_we, bus1.rf_waddr);
        end
        tests++; if (bus1.rf_wdata !== 16'h0009) begin fails++; $display("FAIL and_wdata: got %h exp 0009", bus1.rf_wdata); end
        @(negedge clk);
        tests++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.rf_we !== 1'b0) begin
            fails++; $display("FAIL and_after_wb: got busy %b done %b we %b exp 0 0 0", bus1.busy, bus1.done, bus1.rf_we);
        end
        tests++; if (rf1[3] !== 16'h0009) begin fails++; $display("FAIL and_rf3: got %h exp 0009", rf1[3]); end
    endtask

    task automatic test_or_chain();
        int n;
        issue(1'b0, 2'd1, 4'd4, 4'd5, 4'd4);
        wait_done(1'b0, 1, n);
        tests++; if (n != 5 || bus1.rf_wdata !== 16'hFFFF) begin
            fails++; $display("FAIL or_wdata: got n %0d data %h exp 5 ffff", n, bus1.rf_wdata);
        end
        @(negedge clk);
        tests++; if (rf1[4] !== 16'hFFFF) begin fails++; $display("FAIL or_rf4: got %h exp ffff", rf1[4]); end
        issue(1'b0, 2'd0, 4'd4, 4'd5, 4'd8);
        wait_done(1'b0, 1, n);
        tests++; if (bus1.lu_inp1 !== 16'hFFFF) begin fails++; $display("FAIL chain_inp1: got %h exp ffff", bus1.lu_inp1); end
        tests++; if (bus1.rf_wdata !== 16'h0FF0 || bus1.rf_waddr !== 4'd8) begin
            fails++; $display("FAIL chain_write: got %h @%h exp 0ff0 @8", bus1.rf_wdata, bus1.rf_waddr);
        end
        @(negedge clk);
    endtask

    task automatic test_not_xor();
        int n;
        issue(1'b0, 2'd3, 4'd6, 4'd7, 4'd9);
        wait_done(1'b0, 1, n);
        tests++; if (bus1.lu_inp2 !== 16'h0000) begin fails++; $display("FAIL not_inp2: got %h exp 0000", bus1.lu_inp2); end
        tests++; if (n != 5 || bus1.rf_wdata !== 16'hFF00) begin
            fails++; $display("FAIL not_wdata: got n %0d data %h exp 5 ff00", n, bus1.rf_wdata);
        end
        @(negedge clk);
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        tests++; if (bus1.zero !== 1'b0) begin fails++; $display("FAIL not_zero: got %b exp 0", bus1.zero); end
`endif
        issue(1'b0, 2'd2, 4'd6, 4'd6, 4'd10);
        wait_done(1'b0, 1, n);
        tests++; if (bus1.rf_wdata !== 16'h0000 || bus1.rf_waddr !== 4'd10) begin
            fails++; $display("FAIL xor_same: got %h @%h exp 0000 @a", bus1.rf_wdata, bus1.rf_waddr);
        end
        @(negedge clk);
        tests++; if (rf1[10] !== 16'h0000) begin fails++; $display("FAIL xor_rf10: got %h exp 0000", rf1[10]); end
`ifdef LOGIC_SEQ_ZERO_FLAG_EN
        tests++; if (bus1.zero !== 1'b1) begin fails++; $display("FAIL xor_zero: got %b exp 1", bus1.zero); end
`endif
    endtask

    task automatic test_back_to_back();
        int n;
        int we0;
        we0 = we_cnt1;
        issue(1'b0, 2'd0, 4'd1, 4'd2, 4'd11);
        @(negedge clk);
        start1 = 1'b1; op = 2'd1; s1 = 4'd4; s2 = 4'd4; dst = 4'd12;
        @(negedge clk);
        start1 = 1'b0;
        wait_done(1'b0, 3, n);
        tests++; if (n != 5 || bus1.rf_waddr !== 4'd11 || bus1.rf_wdata !== 16'h0009) begin
            fails++; $display("FAIL b2b_first: got n %0d %h @%h exp 5 0009 @b", n, bus1.rf_wdata, bus1.rf_waddr);
        end
        start1 = 1'b1; op = 2'd2; s1 = 4'd1; s2 = 4'd2; dst = 4'd13;
        @(negedge clk);
        start1 = 1'b0;
        tests++; if (bus1.busy !== 1'b0) begin fails++; $display("FAIL b2b_wb_start: got busy %b exp 0", bus1.busy); end
        repeat (6) @(negedge clk);
        tests++; if (we_cnt1 - we0 != 1) begin fails++; $display("FAIL b2b_writes: got %0d exp 1", we_cnt1 - we0); end
        tests++; if (rf1[12] !== 16'h5A5A || rf1[13] !== 16'h5A5A) begin
            fails++; $display("FAIL b2b_untouched: got %h %h exp 5a5a 5a5a", rf1[12], rf1[13]);
        end
        issue(1'b0, 2'd1, 4'd1, 4'd2, 4'd12);
        wait_done(1'b0, 1, n);
        tests++; if (n != 5 || bus1.rf_wdata !== 16'h000F) begin
            fails++; $display("FAIL b2b_next: got n %0d data %h exp 5 000f", n, bus1.rf_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n;
        int we0;
        we0 = we_cnt1;
        issue(1'b0, 2'd1, 4'd1, 4'd2, 4'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.rf_we !== 1'b0) begin
            fails++; $display("FAIL rstmid_state: got busy %b done %b we %b exp 0 0 0", bus1.busy, bus1.done, bus1.rf_we);
        end
        repeat (5) @(negedge clk);
        tests++; if (we_cnt1 != we0 || rf1[3] !== 16'h0009) begin
            fails++; $display("FAIL rstmid_nowrite: got writes %0d rf3 %h exp 0 0009", we_cnt1 - we0, rf1[3]);
        end
        issue(1'b0, 2'd2, 4'd1, 4'd2, 4'd3);
        wait_done(1'b0, 1, n);
        tests++; if (n != 5 || bus1.rf_wdata !== 16'h0006) begin
            fails++; $display("FAIL rstmid_resume: got n %0d data %h exp 5 0006", n, bus1.rf_wdata);
        end
        @(negedge clk);
    endtask

    task automatic test_latency3();
        int n;
        issue(1'b1, 2'd2, 4'd14, 4'd15, 4'd0);
        n = 1;
        while (bus3.done !== 1'b1 && n < 20) begin
            if (n >= 4 && n <= 6) begin
                tests++;
                if (bus3.lu_inp1 !== 16'hAAAA || bus3.lu_inp2 !== 16'h5555 || bus3.lu_op !== 2'd2) begin
                    fails++; $display("FAIL lat3_hold c%0d: got %h %h %h exp aaaa 5555 2", n, bus3.lu_inp1, bus3.lu_inp2, bus3.lu_op);
                end
            end
            @(negedge clk);
            n++;
        end
        tests++; if (n != 7) begin fails++; $display("FAIL lat3_latency: got %0d exp 7", n); end
        tests++; if (bus3.rf_wdata !== 16'hFFFF || bus3.rf_waddr !== 4'd0) begin
            fails++; $display("FAIL lat3_write: got %h @%h exp ffff @0", bus3.rf_wdata, bus3.rf_waddr);
        end
        @(negedge clk);
        tests++; if (rf3[0] !== 16'hFFFF || bus3.busy !== 1'b0) begin
            fails++; $display("FAIL lat3_after: got rf0 %h busy %b exp ffff 0", rf3[0], bus3.busy);
        end
    endtask

    initial begin
        rst = 1'b1; start1 = 1'b0; start3 = 1'b0;
        op = 2'd0; s1 = 4'd0; s2 = 4'd0; dst = 4'd0;
        pre_we = 1'b0; pre_addr = 4'd0; pre_data = 16'h0;
        tests = 0; fails = 0;
        test_reset();
        preload(4'd1, 16'h000B);
        preload(4'd2, 16'h000D);
        preload(4'd4, 16'hF00F);
        preload(4'd5, 16'h0FF0);
        preload(4'd6, 16'h00FF);
        preload(4'd7, 16'h1234);
        preload(4'd12, 16'h5A5A);
        preload(4'd13, 16'h5A5A);
        preload(4'd14, 16'hAAAA);
        preload(4'd15, 16'h5555);
        test_and();
        test_or_chain();
        test_not_xor();
        test_back_to_back();
        test_reset_mid();
        test_latency3();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
